change_dispenser: RTL and testbench

- Downstream of the vending machine FSM. Takes the change amount the FSM produces and pays it out as physical coins.
- Uses a greedy largest-coin-first policy and keeps per-denomination tube inventory.
- Handshakes each coin ejection with the ejector mechanism.
- Reports any amount it could not pay (shortfall) and any ejector timeout (fault).

---
 rtl/change_dispenser.sv | 205 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out as physical coins, largest coin
// first, tracking per-denomination tube inventory and handshaking each coin
// with the ejector. Unpaid residue is reported as shortfall and an ejector
// that never acknowledges raises a sticky fault.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for a change request
// SELECT   | pick the largest coin that fits the remaining amount and is stocked
// WAIT_ACK | one coin requested from the ejector, waiting for ack or timeout
// DONE     | one-cycle completion pulse, shortfall is valid

module change_dispenser #(
  parameter int TUBE_DEPTH  = 15,
  parameter int INIT_COUNT  = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       change_valid,
  input  logic [7:0] change_amt,
  output logic       change_ready,
  output logic       eject_req,
  output logic [1:0] eject_denom,
  input  logic       eject_ack,
  input  logic       refill_en,
  input  logic [1:0] refill_denom,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       fault,
  output logic [3:0] tube_empty
);

  localparam int CW = $clog2(TUBE_DEPTH + 1);
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(TUBE_DEPTH);
  localparam logic [CW-1:0] COUNT_INIT = CW'(INIT_COUNT);
  // Last timer value before the timeout fires: the timer would reach
  // ACK_TIMEOUT on this edge, so eject_req stays up exactly ACK_TIMEOUT cycles.
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SELECT   = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [7:0]      r_remaining;
  logic [1:0]      r_eject_denom;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_shortfall;
  logic            r_fault;
  logic [CW-1:0]   r_count [4];

  logic            w_found;
  logic [1:0]      w_sel_denom;
  logic            w_ack_take;
  logic            w_timeout;

  // Coin face value in credit units for each tube index.
  function automatic logic [7:0] coin_value(input logic [1:0] denom);
    logic [7:0] v;
    case (denom)
      2'd0:    v = 8'd10;
      2'd1:    v = 8'd20;
      2'd2:    v = 8'd50;
      default: v = 8'd100;
    endcase
    return v;
  endfunction

  // Greedy pick: ascending scan, so the last hit is the largest payable coin.
  // remaining=0 never matches because every coin is worth at least 10.
  always_comb begin
    w_found     = 1'b0;
    w_sel_denom = 2'd0;
    for (int d = 0; d < 4; d++) begin
      if ((coin_value(2'(d)) <= r_remaining) && (r_count[d] != '0)) begin
        w_found     = 1'b1;
        w_sel_denom = 2'(d);
      end
    end
  end

  assign w_ack_take = (r_state == S_WAIT_ACK) && eject_ack;
  assign w_timeout  = (r_state == S_WAIT_ACK) && !eject_ack && (r_timer == TIMER_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and Moore outputs decoded from the registered state.
  always_comb begin
    w_next_state = r_state;
    change_ready = 1'b0;
    eject_req    = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        change_ready = 1'b1;
        if (change_valid) begin
          w_next_state = S_SELECT;
        end
      end
      S_SELECT: begin
        w_next_state = w_found ? S_WAIT_ACK : S_DONE;
      end
      S_WAIT_ACK: begin
        eject_req = 1'b1;
        if (eject_ack) begin
          w_next_state = S_SELECT;
        end else if (w_timeout) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Payout datapath: remaining amount, selected coin, ack timer, results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_remaining   <= 8'd0;
      r_eject_denom <= 2'd0;
      r_timer       <= '0;
      r_shortfall   <= 8'd0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (change_valid) begin
            r_remaining <= change_amt;
          end
        end
        S_SELECT: begin
          if (w_found) begin
            r_eject_denom <= w_sel_denom;
            r_timer       <= '0;
          end else begin
            r_shortfall <= r_remaining;
          end
        end
        S_WAIT_ACK: begin
          if (eject_ack) begin
            // SELECT only picks coins that fit, so this cannot underflow.
            r_remaining <= r_remaining - coin_value(r_eject_denom);
          end else if (w_timeout) begin
            r_fault     <= 1'b1;
            r_shortfall <= r_remaining;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tube inventory: a refill overrides a same-cycle ack decrement on that tube.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) begin
        r_count[d] <= COUNT_INIT;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (refill_en && (refill_denom == 2'(d))) begin
          r_count[d] <= COUNT_FULL;
        end else if (w_ack_take && (r_eject_denom == 2'(d))) begin
          r_count[d] <= r_count[d] - CW'(1);
        end
      end
    end
  end

  // Empty flags straight from the counts.
  always_comb begin
    tube_empty = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      tube_empty[d] = (r_count[d] == '0);
    end
  end

  assign eject_denom = r_eject_denom;
  assign shortfall   = r_shortfall;
  assign fault       = r_fault;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed plus randomized payouts against a
// transaction-level greedy model; a monitor pops expected coins and
// completion results as the DUT presents them.

module tb_change_dispenser;

  localparam int TUBE_DEPTH  = 15;
  localparam int INIT_COUNT  = 8;
  localparam int ACK_TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       change_valid = 1'b0;
  logic [7:0] change_amt = 8'd0;
  logic       change_ready;
  logic       eject_req;
  logic [1:0] eject_denom;
  logic       eject_ack = 1'b0;
  logic       refill_en = 1'b0;
  logic [1:0] refill_denom = 2'd0;
  logic       done;
  logic [7:0] shortfall;
  logic       fault;
  logic [3:0] tube_empty;

  always #5 clk = ~clk;

  change_dispenser #(
    .TUBE_DEPTH (TUBE_DEPTH),
    .INIT_COUNT (INIT_COUNT),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .change_valid(change_valid),
    .change_amt  (change_amt),
    .change_ready(change_ready),
    .eject_req   (eject_req),
    .eject_denom (eject_denom),
    .eject_ack   (eject_ack),
    .refill_en   (refill_en),
    .refill_denom(refill_denom),
    .done        (done),
    .shortfall   (shortfall),
    .fault       (fault),
    .tube_empty  (tube_empty)
  );

  typedef struct {
    int shortfall;
    int fault;
    int empty;
  } done_t;

  int    checks = 0;
  int    failures = 0;
  int    m_cnt [4];
  int    m_fault = 0;
  int    exp_denom_q [$];
  done_t exp_done_q [$];
  int    ack_mode = 0;     // 0 auto ack, 1 never ack, 2 driven by the test
  int    fixed_delay = 2;  // <0 selects a random ack delay

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic int coin_val(input int d);
    return (d == 0) ? 10 : (d == 1) ? 20 : (d == 2) ? 50 : 100;
  endfunction

  function automatic int model_empty();
    int e = 0;
    for (int d = 0; d < 4; d++) if (m_cnt[d] == 0) e |= (1 << d);
    return e;
  endfunction

  // Whole payout worked out at request time from the greedy rule.
  task automatic model_payout(input int amt, input bit timeout);
    int    rem = amt;
    int    best;
    done_t e;
    while (1) begin
      best = -1;
      for (int d = 0; d < 4; d++) if (coin_val(d) <= rem && m_cnt[d] > 0) best = d;
      if (best < 0) break;
      exp_denom_q.push_back(best);
      if (timeout) begin
        m_fault = 1;
        break;
      end
      m_cnt[best]--;
      rem -= coin_val(best);
    end
    e.shortfall = rem;
    e.fault     = m_fault;
    e.empty     = model_empty();
    exp_done_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) m_cnt[d] = INIT_COUNT;
    m_fault = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!change_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!change_ready) chk("ready_wait", change_ready, 1);
  endtask

  task automatic issue(input int amt);
    change_valid = 1'b1;
    change_amt   = 8'(amt);
    @(posedge clk);
    #1;
    change_valid = 1'b0;
  endtask

  task automatic send(input int amt, input bit timeout);
    wait_ready();
    model_payout(amt, timeout);
    issue(amt);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_wait", done, 1);
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!eject_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!eject_req) chk("req_wait", eject_req, 1);
  endtask

  task automatic refill(input int d);
    @(negedge clk);
    refill_en    = 1'b1;
    refill_denom = 2'(d);
    m_cnt[d]     = TUBE_DEPTH;
    @(negedge clk);
    refill_en    = 1'b0;
  endtask

  // Ejector model: acknowledges each requested coin after a short delay.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (ack_mode == 0 && eject_req) begin
        if (fixed_delay >= 0) d = fixed_delay;
        else d = int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        eject_ack = 1'b1;
        @(negedge clk);
        eject_ack = 1'b0;
      end
    end
  end

  // Monitor: every coin request and every done pulse is matched to the model.
  initial begin
    bit    prev_req = 1'b0;
    bit    prev_done = 1'b0;
    int    exp_cur = 0;
    done_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req  = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (eject_req && !prev_req) begin
          if (exp_denom_q.size() == 0) begin
            chk("eject_expected", exp_denom_q.size(), 1);
          end else begin
            exp_cur = exp_denom_q.pop_front();
            chk("eject_denom", eject_denom, exp_cur);
          end
        end else if (eject_req) begin
          chk("denom_stable", eject_denom, exp_cur);
        end
        if (done) begin
          chk("done_one_cycle", prev_done, 0);
          if (exp_done_q.size() == 0) begin
            chk("done_expected", exp_done_q.size(), 1);
          end else begin
            e = exp_done_q.pop_front();
            chk("shortfall", shortfall, e.shortfall);
            chk("fault", fault, e.fault);
            chk("tube_empty", tube_empty, e.empty);
          end
        end
        prev_req  = eject_req;
        prev_done = done;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    done_t e;
    int    len;
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", change_ready, 1);
    chk("rst_eject_req", eject_req, 0);
    chk("rst_eject_denom", eject_denom, 0);
    chk("rst_done", done, 0);
    chk("rst_shortfall", shortfall, 0);
    chk("rst_fault", fault, 0);
    chk("rst_tube_empty", tube_empty, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 80 -> 50, 20, 10 with acks two cycles after each request.
    fixed_delay = 2;
    send(80, 0);
    wait_done();

    // Zero amount: done two edges after acceptance, no coin.
    wait_ready();
    model_payout(0, 0);
    issue(0);
    chk("zero_k1_done", done, 0);
    @(posedge clk);
    #1;
    chk("zero_k2_done", done, 1);
    chk("zero_k2_req", eject_req, 0);
    @(negedge clk);

    // 35 -> 20, 10, shortfall 5 with prompt acks.
    fixed_delay = 0;
    send(35, 0);
    wait_done();

    // Randomized payouts with occasional refills between requests.
    fixed_delay = -1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) refill(int'($urandom_range(0, 3)));
      send(int'($urandom_range(0, 255)), 0);
      wait_done();
    end

    // Ejector never acknowledges: timeout, sticky fault, no decrement.
    refill(2);
    ack_mode = 1;
    send(50, 1);
    wait_req();
    len = 0;
    while (eject_req && len < 1000) begin
      len++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", len, ACK_TIMEOUT);
    wait_done();
    ack_mode = 0;
    send(20, 0);
    wait_done();

    // Reset while waiting for an ack abandons the payout.
    ack_mode = 1;
    refill(2);
    wait_ready();
    exp_denom_q.push_back(2);
    issue(50);
    wait_req();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_eject_req", eject_req, 0);
    chk("midrst_ready", change_ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_fault", fault, 0);
    chk("midrst_shortfall", shortfall, 0);
    chk("midrst_tube_empty", tube_empty, 0);
    model_reset();
    exp_done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ack_mode = 0;
    // Nine 100s: the ninth finds the 100 tube empty only if it restarted at INIT_COUNT.
    for (int i = 0; i < 9; i++) begin
      send(100, 0);
      wait_done();
    end

    // Refill on tube 1 in the same cycle as its ack: refill wins.
    ack_mode = 2;
    wait_ready();
    exp_denom_q.push_back(1);
    m_cnt[1]    = TUBE_DEPTH;
    e.shortfall = 0;
    e.fault     = m_fault;
    e.empty     = model_empty();
    exp_done_q.push_back(e);
    issue(20);
    wait_req();
    eject_ack    = 1'b1;
    refill_en    = 1'b1;
    refill_denom = 2'd1;
    @(negedge clk);
    eject_ack = 1'b0;
    refill_en = 1'b0;
    wait_done();
    ack_mode = 0;
    for (int i = 0; i < 16; i++) begin
      send(20, 0);
      wait_done();
    end

    // Drain every tube to one coin, then 150 and 70.
    for (int d = 0; d < 4; d++) refill(d);
    for (int d = 3; d >= 0; d--) begin
      for (int i = 0; i < 14; i++) begin
        send(coin_val(d), 0);
        wait_done();
      end
    end
    send(150, 0);
    wait_done();
    send(70, 0);
    wait_done();
    chk("drain_tube_empty", tube_empty, 4'b1111);

    repeat (3) @(negedge clk);
    chk("leftover_coins", exp_denom_q.size(), 0);
    chk("leftover_dones", exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
